fetch_unit: RTL

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core.
- Sits directly upstream of decode and the stall controller.
- Generates the PC and issues requests to instruction memory over a valid/ready handshake.
- Buffers in-order responses and drives the ID-stage instruction fields, including the opcode and rs1/rs2 addresses consumed by stall control.
- Holds on stall; flushes and redirects on a taken branch or jump.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared constants and types for the instruction-fetch stage.
//                c_nop_instr     - canonical bubble (addi x0, x0, 0)
//                c_reset_pc      - default first fetch address
//                c_opcode_opimm  - opcode a bubble reports in ID
//                fetch_entry_t   - {pc, instr} pair held in the fetch buffer
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam logic [31:0] c_nop_instr    = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc     = 32'h0000_0000;
    localparam logic [6:0]  c_opcode_opimm = 7'h13;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO, DEPTH a power of two (>= 2).
//                Simultaneous push and pop are allowed, including when full.
//                i_clear empties the FIFO and wins over push/pop.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                i_clear          - discard all contents
//                i_push/i_wr_data - write port
//                i_pop/o_rd_data  - read port (o_rd_data shows the head)
//                o_count/o_empty/o_full - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: nothing is read until the count says it is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = w_empty;
    assign o_full    = w_full;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage and IF/ID pipeline register.
//                Issues PC requests over a valid/ready handshake, pairs
//                in-order responses with their PCs, buffers them and feeds
//                the ID register. Holds on stall; flushes on redirect.
//  Ports       : clk, reset (async, active-low)
//                stall_ip, redirect_valid_ip, redirect_pc_ip - control
//                imem_req_*  - request channel to instruction memory
//                imem_rsp_*  - in-order response channel
//                ID_*        - IF/ID register outputs and source fields
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_reset_pc,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_ip,
    input  logic        redirect_valid_ip,
    input  logic [31:0] redirect_pc_ip,
    output logic        imem_req_valid_op,
    output logic [31:0] imem_req_addr_op,
    input  logic        imem_req_ready_ip,
    input  logic        imem_rsp_valid_ip,
    input  logic [31:0] imem_rsp_data_ip,
    output logic        ID_valid_op,
    output logic [31:0] ID_pc_op,
    output logic [31:0] ID_instr_op,
    output logic [6:0]  ID_instr_opcode_op,
    output logic [4:0]  ID_src1_addr_op,
    output logic [4:0]  ID_src2_addr_op
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             r_run;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_id_valid;
    logic [31:0]      r_id_pc;
    logic [31:0]      r_id_instr;

    logic [CNT_W-1:0] w_inflight_cnt;
    logic             w_inflight_empty;
    logic             w_inflight_full;
    logic [31:0]      w_rsp_pc;

    logic [CNT_W-1:0] w_buf_cnt;
    logic             w_buf_empty;
    logic             w_buf_full;
    fetch_entry_t     w_buf_head;
    fetch_entry_t     w_buf_wr;

    logic [CNT_W:0]   w_credits_used;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp;
    logic             w_rsp_dropping;
    logic             w_rsp_keep;
    logic             w_advance;
    logic             w_take_head;
    logic             w_bypass;
    logic             w_buf_push;
    logic [CNT_W-1:0] w_drop_next;

    // ------------------------------------------------------------------
    // Issue: a request needs a credit; in-flight and buffered entries
    // (including ones destined to be dropped) both hold one.
    // ------------------------------------------------------------------
    assign w_credits_used = {1'b0, w_inflight_cnt} + {1'b0, w_buf_cnt};
    assign w_req_valid    = r_run && (w_credits_used < (CNT_W+1)'(FIFO_DEPTH));
    assign w_req_fire     = w_req_valid && imem_req_ready_ip;

    // ------------------------------------------------------------------
    // Response routing. A response with nothing in flight is a protocol
    // error and is ignored.
    // ------------------------------------------------------------------
    assign w_rsp          = imem_rsp_valid_ip && !w_inflight_empty;
    assign w_rsp_dropping = w_rsp && (r_drop_cnt != '0);
    assign w_rsp_keep     = w_rsp && !w_rsp_dropping && !redirect_valid_ip;

    assign w_advance   = !redirect_valid_ip && !stall_ip;
    assign w_take_head = w_advance && !w_buf_empty;
    // Bypass only when the buffer is empty so program order is preserved.
    assign w_bypass    = w_advance && w_buf_empty && w_rsp_keep;
    assign w_buf_push  = w_rsp_keep && !w_bypass;

    assign w_buf_wr.pc    = w_rsp_pc;
    assign w_buf_wr.instr = imem_rsp_data_ip;

    // Everything still in flight after a redirect edge is stale: the
    // current count, less a response retiring now, plus a request firing now.
    assign w_drop_next = w_inflight_cnt - CNT_W'(w_rsp) + CNT_W'(w_req_fire);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_inflight_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_clear   (1'b0),
        .i_push    (w_req_fire),
        .i_wr_data (r_pc),
        .i_pop     (w_rsp),
        .o_rd_data (w_rsp_pc),
        .o_count   (w_inflight_cnt),
        .o_empty   (w_inflight_empty),
        .o_full    (w_inflight_full)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (reset),
        .i_clear   (redirect_valid_ip),
        .i_push    (w_buf_push),
        .i_wr_data (w_buf_wr),
        .i_pop     (w_take_head),
        .o_rd_data (w_buf_head),
        .o_count   (w_buf_cnt),
        .o_empty   (w_buf_empty),
        .o_full    (w_buf_full)
    );

    // PC, drop counter and the run flag that keeps requests low in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run      <= 1'b0;
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid_ip) begin
                r_pc       <= redirect_pc_ip;
                r_drop_cnt <= w_drop_next;
            end else begin
                if (w_req_fire)     r_pc       <= r_pc + 32'd4;
                if (w_rsp_dropping) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
        end
    end

    // IF/ID register. Redirect beats stall; a bubble keeps the old PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_instr <= c_nop_instr;
        end else if (redirect_valid_ip) begin
            r_id_valid <= 1'b0;
            r_id_instr <= c_nop_instr;
        end else if (!stall_ip) begin
            if (w_take_head) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= w_buf_head.pc;
                r_id_instr <= w_buf_head.instr;
            end else if (w_bypass) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= w_rsp_pc;
                r_id_instr <= imem_rsp_data_ip;
            end else begin
                r_id_valid <= 1'b0;
                r_id_instr <= c_nop_instr;
            end
        end
    end

    assign imem_req_valid_op  = w_req_valid;
    assign imem_req_addr_op   = r_pc;
    assign ID_valid_op        = r_id_valid;
    assign ID_pc_op           = r_id_pc;
    assign ID_instr_op        = r_id_instr;
    assign ID_instr_opcode_op = r_id_instr[6:0];
    assign ID_src1_addr_op    = r_id_instr[19:15];
    assign ID_src2_addr_op    = r_id_instr[24:20];

    a_rsp_needs_request: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid_ip && w_inflight_empty));
    a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
        w_credits_used <= (CNT_W+1)'(FIFO_DEPTH));
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_buf_push && w_buf_full && !w_take_head));
    a_inflight_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_req_fire && w_inflight_full && !w_rsp));

endmodule
`default_nettype wire
